axis_stall_detector: RTL and testbench

AXIS_STALL_DETECTOR -- requirements
Module: axis_stall_detector

---
 rtl/axis_stall_detector_pkg.sv | 14 +
 rtl/axis_stall_chan.sv | 69 ++++++
 rtl/axis_stall_detector.sv | 82 ++++++++
 tb/tb_axis_stall_detector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/axis_stall_detector_pkg.sv
// Shared types and default constants for the AXI-stream stall detector.
package axis_stall_detector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    BLOCKED = 2'd2
  } chan_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_STALL_LIMIT = 8;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/axis_stall_chan.sv
// Per-channel stall tracker: IDLE/STALL/BLOCKED FSM plus a consecutive-stall counter.
module axis_stall_chan
  import axis_stall_detector_pkg::*;
#(
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic is_input,
  input  logic tvalid,
  input  logic tready,
  output logic blocked,
  output logic stalling
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             stall;

  // A consumer stalls when it is ready but starved; a producer stalls when it offers data nobody takes.
  assign stall   = is_input ? (tready & ~tvalid) : (tvalid & ~tready);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and counter: any non-stall cycle or disabled monitoring collapses back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable || !stall) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = STALL;
          cnt_d   = CNT_W'(1);
        end
        STALL: begin
          cnt_d = cnt_inc;
          if (cnt_inc == LIMIT) state_d = BLOCKED;
        end
        BLOCKED: cnt_d = LIMIT;  // saturated while blocked
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign blocked  = (state_q == BLOCKED);
  assign stalling = (state_q != IDLE);

endmodule

// File: rtl/axis_stall_detector.sv
// Multi-channel AXI-stream stall detector: per-channel trackers, stall_any reduction and first-block capture.
module axis_stall_detector
  import axis_stall_detector_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [NUM_CH-1:0]         ch_is_input,
  input  logic [NUM_CH-1:0]         tvalid,
  input  logic [NUM_CH-1:0]         tready,
  output logic [NUM_CH-1:0]         axis_block_sigs,
  output logic                      stall_any,
  output logic                      first_block_valid,
  output logic [$clog2(NUM_CH)-1:0] first_block_ch
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] stalling;
  logic              fbv_q, fbv_d;
  logic [CH_W-1:0]   fbch_q, fbch_d;
  logic [CH_W-1:0]   lowest;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axis_stall_chan #(
      .STALL_LIMIT (STALL_LIMIT),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .is_input (ch_is_input[g]),
      .tvalid   (tvalid[g]),
      .tready   (tready[g]),
      .blocked  (axis_block_sigs[g]),
      .stalling (stalling[g])
    );
  end

  assign stall_any = |stalling;

  // Priority encoder: lowest-index blocked channel wins.
  always_comb begin
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (axis_block_sigs[i]) lowest = CH_W'(i);
    end
  end

  // First-block capture: sticky until clear, and clear beats a same-cycle capture.
  always_comb begin
    fbv_d  = fbv_q;
    fbch_d = fbch_q;
    if (clear) begin
      fbv_d  = 1'b0;
      fbch_d = '0;
    end else if (!fbv_q && |axis_block_sigs) begin
      fbv_d  = 1'b1;
      fbch_d = lowest;
    end
  end

  // Capture registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fbv_q  <= 1'b0;
      fbch_q <= '0;
    end else begin
      fbv_q  <= fbv_d;
      fbch_q <= fbch_d;
    end
  end

  assign first_block_valid = fbv_q;
  assign first_block_ch    = fbch_q;

endmodule

// File: tb/tb_axis_stall_detector.sv
// Scoreboard bench: driver updates a run-length reference model per edge and queues expectations; monitor compares.
module tb_axis_stall_detector;

  localparam int NUM_CH = 4;
  localparam int LIMIT  = 8;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [NUM_CH-1:0] sigs;
    logic              any;
    logic              fbv;
    logic [1:0]        ch;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset, enable, clear;
  logic [NUM_CH-1:0] ch_is_input, tvalid, tready;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              stall_any, first_block_valid;
  logic [1:0]        first_block_ch;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model: consecutive stall samples per channel plus capture flag
  int   run [NUM_CH];
  bit   m_fbv;
  int   m_fbch;

  axis_stall_detector #(.NUM_CH(NUM_CH), .STALL_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .clear             (clear),
    .ch_is_input       (ch_is_input),
    .tvalid            (tvalid),
    .tready            (tready),
    .axis_block_sigs   (axis_block_sigs),
    .stall_any         (stall_any),
    .first_block_valid (first_block_valid),
    .first_block_ch    (first_block_ch)
  );

  always #5 clock = ~clock;

  function automatic bit is_stall(int i);
    if (ch_is_input[i]) return tready[i] && !tvalid[i];
    return tvalid[i] && !tready[i];
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    exp_t e;
    logic [NUM_CH-1:0] blk;
    for (int i = 0; i < NUM_CH; i++) blk[i] = (run[i] >= LIMIT);
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) run[i] = 0;
      m_fbv = 0; m_fbch = 0;
    end else begin
      if (clear) begin
        m_fbv = 0; m_fbch = 0;
      end else if (!m_fbv && blk != 0) begin
        m_fbv = 1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (blk[i]) m_fbch = i;
      end
      for (int i = 0; i < NUM_CH; i++) run[i] = (enable && is_stall(i)) ? run[i] + 1 : 0;
    end
    e.any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      e.sigs[i] = (run[i] >= LIMIT);
      if (run[i] > 0) e.any = 1'b1;
    end
    e.fbv = m_fbv;
    e.ch  = 2'(m_fbch);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, wait for the edge, then record the expectation.
  task automatic cyc(input logic r, input logic en, input logic cl,
                     input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] rd);
    reset = r; enable = en; clear = cl; tvalid = v; tready = rd;
    @(posedge clock);
    #1;
    model_edge();
  endtask

  // Stall the channels in mask; all others transfer.
  task automatic stall_cyc(input logic r, input logic en, input logic cl, input logic [NUM_CH-1:0] mask);
    logic [NUM_CH-1:0] v, rd;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        v[i]  = ch_is_input[i] ? 1'b0 : 1'b1;
        rd[i] = ch_is_input[i] ? 1'b1 : 1'b0;
      end else begin
        v[i] = 1'b1; rd[i] = 1'b1;
      end
    end
    cyc(r, en, cl, v, rd);
  endtask

  // Monitor: compare every registered output against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (axis_block_sigs !== e.sigs) begin
        failures++;
        $display("FAIL sigs t=%0t got=%b exp=%b", $time, axis_block_sigs, e.sigs);
      end
      checks++;
      if (stall_any !== e.any) begin
        failures++;
        $display("FAIL stall_any t=%0t got=%b exp=%b", $time, stall_any, e.any);
      end
      checks++;
      if (first_block_valid !== e.fbv) begin
        failures++;
        $display("FAIL fb_valid t=%0t got=%b exp=%b", $time, first_block_valid, e.fbv);
      end
      checks++;
      if (first_block_ch !== e.ch) begin
        failures++;
        $display("FAIL fb_ch t=%0t got=%0d exp=%0d", $time, first_block_ch, e.ch);
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] mode, v, rd;
    int wait_cnt;
    ch_is_input = 4'b0011;
    for (int i = 0; i < NUM_CH; i++) run[i] = 0;
    m_fbv = 0; m_fbch = 0;

    repeat (2) stall_cyc(1, 1, 0, 4'b0000);

    // ch0 held stalled: blocks at cycle 8, capture one later
    repeat (12) stall_cyc(0, 1, 0, 4'b0001);
    // transfer on ch0 drops the block, capture stays
    stall_cyc(0, 1, 0, 4'b0000);
    repeat (2) stall_cyc(0, 1, 0, 4'b0000);

    // ch2 stalls 7 then transfers, three times: never blocks
    stall_cyc(0, 1, 1, 4'b0000);
    repeat (3) begin
      repeat (7) stall_cyc(0, 1, 0, 4'b0100);
      stall_cyc(0, 1, 0, 4'b0000);
    end

    // ch1 and ch3 together; clear while still blocked forces recapture
    for (int c = 0; c < 16; c++) stall_cyc(0, 1, (c == 12), 4'b1010);
    stall_cyc(0, 1, 1, 4'b0000);

    // ch0 blocked, enable dropped for one cycle, then re-blocks after a full limit
    repeat (10) stall_cyc(0, 1, 0, 4'b0001);
    stall_cyc(0, 0, 0, 4'b0001);
    repeat (10) stall_cyc(0, 1, 0, 4'b0001);
    stall_cyc(0, 1, 1, 4'b0000);

    // reset at stall cycle 5 of ch3
    repeat (5) stall_cyc(0, 1, 0, 4'b1000);
    stall_cyc(1, 1, 0, 4'b1000);
    repeat (10) stall_cyc(0, 1, 0, 4'b1000);

    // randomized bursts with occasional clear, enable drop and reset
    mode = '0;
    repeat (800) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 11) == 0) mode[i] = ~mode[i];
        if (mode[i]) begin
          v[i]  = ch_is_input[i] ? 1'b0 : 1'b1;
          rd[i] = ch_is_input[i] ? 1'b1 : 1'b0;
        end else begin
          v[i]  = 1'($urandom_range(0, 1));
          rd[i] = 1'($urandom_range(0, 1));
        end
      end
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
          ($urandom_range(0, 29) == 0), v, rd);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(negedge clock);
      wait_cnt++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
